// File: rtl/n64_cfg_mbox.sv
// n64_cfg_mbox: N64-side config mailbox with a command FIFO toward the controller CPU.
// Define N64_CFG_MBOX_IRQ_EN to add the irq port and the irq_pending flag.
module n64_cfg_mbox #(
  parameter int NUM_ARGS  = 2,
  parameter int NUM_RESP  = 1,
  parameter int CMD_DEPTH = 4,
  parameter int ADDR_W    = 6
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bus_request,
  input  logic                     bus_write,
  input  logic [ADDR_W-1:0]        bus_address,
  input  logic [15:0]              bus_wdata,
  output logic                     bus_ack,
  output logic [15:0]              bus_rdata,
  input  logic                     cpu_bootstrapped,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_id,
  output logic [32*NUM_ARGS-1:0]   cmd_args,
  input  logic                     rsp_valid,
  input  logic [32*NUM_RESP-1:0]   rsp_data,
  input  logic                     rsp_error
`ifdef N64_CFG_MBOX_IRQ_EN
  ,output logic                    irq
`endif
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = ADDR_W - 1;
  localparam int R0 = 4 + 2 * NUM_ARGS;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0] fifo_id [CMD_DEPTH];
  logic [NUM_ARGS-1:0][31:0] fifo_args [CMD_DEPTH];
  logic [NUM_ARGS-1:0][31:0] args_q;
  logic [NUM_RESP-1:0][31:0] resp_q;
  logic [7:0] last_cmd;
  logic in_flight, overflow, error, irq_bit;
  logic [IW-1:0] idx;
  logic acc, wr, push, ctrl, full, pop, push_ok, rsp_acc;
  logic [15:0] status, rd;
  logic unused_addr_lsb;
  assign unused_addr_lsb = bus_address[0];
  assign idx     = bus_address[ADDR_W-1:1];
  assign acc     = state == S_IDLE && bus_request;
  assign wr      = acc && bus_write;
  assign push    = wr && idx == IW'(1);
  assign ctrl    = wr && idx == IW'(2);
  assign full    = count == CW'(CMD_DEPTH);
  assign cmd_valid = count != '0;
  assign pop     = cmd_valid && cmd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push && (!full || pop);
  assign rsp_acc = rsp_valid && in_flight;
  assign cmd_id   = cmd_valid ? fifo_id[rd_ptr] : '0;
  assign cmd_args = cmd_valid ? fifo_args[rd_ptr] : '0;
`ifdef N64_CFG_MBOX_IRQ_EN
  logic irq_pending;
  assign irq_bit = irq_pending;
  assign irq = irq_pending;
`else
  assign irq_bit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      bus_ack   <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      args_q    <= '0;
      resp_q    <= '0;
      last_cmd  <= '0;
      in_flight <= 1'b0;
      overflow  <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= acc ? S_WAIT : S_IDLE;
      bus_ack   <= acc;
      count     <= count + CW'(push_ok) - CW'(pop);
      wr_ptr    <= wr_ptr + PW'(push_ok);
      rd_ptr    <= rd_ptr + PW'(pop);
      in_flight <= pop || (in_flight && !rsp_valid);
      overflow  <= (push && full && !pop) || (overflow && !(ctrl && bus_wdata[0]));
      error     <= (rsp_acc && rsp_error) || (error && !(ctrl && bus_wdata[1]));
      if (rsp_acc) resp_q <= rsp_data;
      if (push) last_cmd <= bus_wdata[7:0];
      for (int k = 0; k < NUM_ARGS; k++) begin
        if (wr && idx == IW'(4 + 2 * k)) args_q[k][31:16] <= bus_wdata;
        if (wr && idx == IW'(5 + 2 * k)) args_q[k][15:0] <= bus_wdata;
      end
    end
  end
`ifdef N64_CFG_MBOX_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset) irq_pending <= 1'b0;
    else irq_pending <= rsp_acc || (irq_pending && !(ctrl && bus_wdata[2]));
  end
`endif
  // Storage is unreset; outputs are gated by cmd_valid so stale entries never show
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_id[wr_ptr]   <= bus_wdata[7:0];
      fifo_args[wr_ptr] <= args_q;
    end
  end
  assign status = {cpu_bootstrapped, count != '0 || in_flight, error, overflow, irq_bit, 3'b0, 8'(count)};
  always_comb begin
    rd = '0;
    if (idx == IW'(0)) rd = status;
    if (idx == IW'(1)) rd = {8'h00, last_cmd};
    for (int k = 0; k < NUM_ARGS; k++) begin
      if (idx == IW'(4 + 2 * k)) rd = args_q[k][31:16];
      if (idx == IW'(5 + 2 * k)) rd = args_q[k][15:0];
    end
    for (int j = 0; j < NUM_RESP; j++) begin
      if (idx == IW'(R0 + 2 * j)) rd = resp_q[j][31:16];
      if (idx == IW'(R0 + 2 * j + 1)) rd = resp_q[j][15:0];
    end
    bus_rdata = bus_ack ? rd : '0;
  end
endmodule

// File: tb/tb_n64_cfg_mbox.sv
// tb_n64_cfg_mbox: directed vector table plus hand sequences for n64_cfg_mbox (default parameters).
module tb_n64_cfg_mbox;
  logic clk = 1'b0;
  logic reset, bus_request, bus_write, bus_ack, cpu_bootstrapped;
  logic [5:0] bus_address;
  logic [15:0] bus_wdata, bus_rdata;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_error;
  logic [7:0] cmd_id;
  logic [63:0] cmd_args;
  logic [31:0] rsp_data;
`ifdef N64_CFG_MBOX_IRQ_EN
  logic irq;
  localparam logic [15:0] IRQ_BIT = 16'h0800;
`else
  localparam logic [15:0] IRQ_BIT = 16'h0000;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  n64_cfg_mbox dut (
    .clk(clk), .reset(reset), .bus_request(bus_request), .bus_write(bus_write),
    .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .cpu_bootstrapped(cpu_bootstrapped), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_args(cmd_args), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_error(rsp_error)
`ifdef N64_CFG_MBOX_IRQ_EN
    , .irq(irq)
`endif
  );
  typedef struct { bit wr; int idx; logic [15:0] data; logic [15:0] exp; } vec_t;
  vec_t tbl [19];
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic bus_op(input bit wr, input int idx, input logic [15:0] d, input bit pop,
                        output logic [15:0] q, output logic a);
    bus_request = 1'b1; bus_write = wr; bus_address = 6'(idx * 2); bus_wdata = d; cmd_ready = pop;
    @(posedge clk); #1;
    bus_request = 1'b0; cmd_ready = 1'b0;
    a = bus_ack; q = bus_rdata;
    @(posedge clk); #1;
  endtask
  task automatic wr_hw(input int idx, input logic [15:0] d);
    logic [15:0] q; logic a;
    bus_op(1'b1, idx, d, 1'b0, q, a);
  endtask
  task automatic rd_chk(input string nm, input int idx, input logic [15:0] exp);
    logic [15:0] q; logic a;
    bus_op(1'b0, idx, 16'h0, 1'b0, q, a);
    check(nm, 64'(q), 64'(exp));
  endtask
  task automatic pop1();
    cmd_ready = 1'b1; @(posedge clk); #1; cmd_ready = 1'b0;
  endtask
  task automatic rsp_pulse(input logic [31:0] d, input bit e);
    rsp_valid = 1'b1; rsp_data = d; rsp_error = e;
    @(posedge clk); #1;
    rsp_valid = 1'b0; rsp_error = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
  endtask
  initial begin
    logic [15:0] q; logic a;
    reset = 1'b0; bus_request = 1'b0; bus_write = 1'b0; bus_address = '0; bus_wdata = '0;
    cpu_bootstrapped = 1'b1; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_error = 1'b0;
    tbl[0]  = '{0, 0, 16'h0, 16'h8000};
    tbl[1]  = '{1, 4, 16'h1234, 16'h0};
    tbl[2]  = '{1, 5, 16'h5678, 16'h0};
    tbl[3]  = '{1, 6, 16'hAAAA, 16'h0};
    tbl[4]  = '{1, 7, 16'h5555, 16'h0};
    tbl[5]  = '{0, 4, 16'h0, 16'h1234};
    tbl[6]  = '{0, 5, 16'h0, 16'h5678};
    tbl[7]  = '{0, 6, 16'h0, 16'hAAAA};
    tbl[8]  = '{0, 7, 16'h0, 16'h5555};
    tbl[9]  = '{1, 1, 16'h0042, 16'h0};
    tbl[10] = '{0, 0, 16'h0, 16'hC001};
    tbl[11] = '{0, 1, 16'h0, 16'h0042};
    tbl[12] = '{0, 2, 16'h0, 16'h0000};
    tbl[13] = '{0, 3, 16'h0, 16'h0000};
    tbl[14] = '{0, 8, 16'h0, 16'h0000};
    tbl[15] = '{0, 9, 16'h0, 16'h0000};
    tbl[16] = '{1, 31, 16'hFFFF, 16'h0};
    tbl[17] = '{0, 31, 16'h0, 16'h0000};
    tbl[18] = '{0, 0, 16'h0, 16'hC001};
    @(posedge clk); @(posedge clk); #1;
    check("rst_ack", 64'(bus_ack), 0);
    check("rst_rdata", 64'(bus_rdata), 0);
    check("rst_valid", 64'(cmd_valid), 0);
    check("rst_id", 64'(cmd_id), 0);
    check("rst_args", cmd_args, 0);
    reset = 1'b1;
    // register map and first command
    for (int i = 0; i < 19; i++) begin
      bus_op(tbl[i].wr, tbl[i].idx, tbl[i].data, 1'b0, q, a);
      check($sformatf("vec%0d_ack", i), 64'(a), 1);
      if (!tbl[i].wr) check($sformatf("vec%0d_rd", i), 64'(q), 64'(tbl[i].exp));
    end
    check("t1_valid", 64'(cmd_valid), 1);
    check("t1_id", 64'(cmd_id), 64'h42);
    check("t1_args", cmd_args, 64'hAAAA5555_12345678);
    // overflow: five pushes into a depth-4 queue
    do_reset();
    bus_request = 1'b1; bus_write = 1'b1; bus_address = 6'd2; bus_wdata = 16'h0010;
    check("pre_push_valid", 64'(cmd_valid), 0);
    @(posedge clk); #1; bus_request = 1'b0;
    check("push_ack", 64'(bus_ack), 1);
    check("push_valid_lat", 64'(cmd_valid), 1);
    @(posedge clk); #1;
    check("wait_no_ack", 64'(bus_ack), 0);
    for (int i = 1; i < 5; i++) wr_hw(1, 16'(16'h10 + i));
    rd_chk("ovf_status", 0, 16'hD004);
    wr_hw(2, 16'h0001);
    rd_chk("ovf_clear", 0, 16'hC004);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop%0d_id", i), 64'(cmd_id), 64'(8'h10 + i));
      pop1();
    end
    check("ovf_empty", 64'(cmd_valid), 0);
    rd_chk("ovf_inflight", 0, 16'hC000);
    // snapshot independence
    do_reset();
    wr_hw(4, 16'h1111); wr_hw(5, 16'h2222);
    wr_hw(1, 16'h000A);
    wr_hw(4, 16'h9999);
    wr_hw(1, 16'h000B);
    check("snap_a", cmd_args[31:0], 64'h11112222);
    pop1();
    check("snap_b_id", 64'(cmd_id), 64'h0B);
    check("snap_b", cmd_args[31:0], 64'h99992222);
    rd_chk("snap_arg", 4, 16'h9999);
    // response with error
    do_reset();
    wr_hw(1, 16'h0020);
    pop1();
    rsp_pulse(32'hCAFEBABE, 1'b1);
    rd_chk("rsp_hi", 8, 16'hCAFE);
    rd_chk("rsp_lo", 9, 16'hBABE);
    rd_chk("rsp_status", 0, 16'hA000 | IRQ_BIT);
`ifdef N64_CFG_MBOX_IRQ_EN
    check("irq_set", 64'(irq), 1);
`endif
    wr_hw(2, 16'h0006);
    rd_chk("rsp_clr", 0, 16'h8000);
`ifdef N64_CFG_MBOX_IRQ_EN
    check("irq_clr", 64'(irq), 0);
`endif
    rsp_pulse(32'h11111111, 1'b1);
    rd_chk("rsp_ignored_hi", 8, 16'hCAFE);
    rd_chk("rsp_ignored_st", 0, 16'h8000);
    // full queue: push and pop in one cycle
    do_reset();
    for (int i = 0; i < 4; i++) wr_hw(1, 16'(16'h30 + i));
    bus_op(1'b1, 1, 16'h0034, 1'b1, q, a);
    rd_chk("full_pp_status", 0, 16'hC004);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("full_pp_id%0d", i), 64'(cmd_id), 64'(8'h30 + i));
      pop1();
    end
    // empty queue: pop has no effect alongside the push
    do_reset();
    bus_op(1'b1, 1, 16'h0040, 1'b1, q, a);
    rd_chk("empty_pp_status", 0, 16'hC001);
    check("empty_pp_id", 64'(cmd_id), 64'h40);
    // reset with pending and in-flight work
    do_reset();
    for (int i = 0; i < 4; i++) wr_hw(1, 16'(16'h50 + i));
    pop1();
    rd_chk("pre_rst_status", 0, 16'hC003);
    do_reset();
    rd_chk("post_rst_status", 0, 16'h8000);
    check("post_rst_valid", 64'(cmd_valid), 0);
    check("post_rst_id", 64'(cmd_id), 0);
    check("post_rst_args", cmd_args, 0);
    rsp_pulse(32'hDEADBEEF, 1'b0);
    rd_chk("post_rst_rsp_hi", 8, 16'h0000);
    rd_chk("post_rst_rsp_lo", 9, 16'h0000);
    rd_chk("post_rst_last", 1, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/n64_cfg_mbox.md
# n64_cfg_mbox

Parametrised N64-side configuration mailbox with a command queue. It decodes 16-bit N64 bus accesses into status, command, control, argument and response registers. Commands and their argument snapshots are queued in a FIFO toward the controller CPU, so the N64 can post several commands while the CPU is busy. It sits between the N64 bus arbiter and the CPU command interface, and tracks overflow, error and completion.

## Interface
Parameters:
- NUM_ARGS, 2: 32-bit argument words per command (1..8)
- NUM_RESP, 1: 32-bit response words (1..4)
- CMD_DEPTH, 4: command FIFO depth; power of 2, 2..16
- ADDR_W, 6: bus address width; requires 4+2·NUM_ARGS+2·NUM_RESP ≤ 2^(ADDR_W-1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- bus_request  in  1  N64 access strobe
- bus_write  in  1  1 = write, 0 = read
- bus_address  in  ADDR_W  byte address; halfword index = bus_address[ADDR_W-1:1]
- bus_wdata  in  16  write data
- bus_ack  out  1  one-cycle access acknowledge
- bus_rdata  out  16  read data, valid only while bus_ack=1, else 0
- cpu_bootstrapped  in  1  CPU ready flag, reported in status
- cmd_valid  out  1  FIFO head valid
- cmd_ready  in  1  CPU accepts head
- cmd_id  out  8  head command code
- cmd_args  out  32·NUM_ARGS  head argument snapshot; arg[0] in the LSBs
- rsp_valid  in  1  one-cycle completion strobe from CPU
- rsp_data  in  32·NUM_RESP  response words
- rsp_error  in  1  completion carries error
- irq  out  1  completion interrupt (only with the macro)

## Operation
Halfword map (index i):
- 0 (R): {cpu_bootstrapped, busy, error, overflow, irq_pending, 3'b0, pending[7:0]}
  - busy = pending≠0 or in_flight
  - pending is the FIFO occupancy, zero-extended
- 1 (W): push {wdata[7:0], arg snapshot}; reads return the last written command code
- 2 (W): bit0 clears overflow, bit1 clears error, bit2 clears irq_pending; reads return 0
- 3: reserved
- 4+2k / 5+2k: arg[k][31:16] / [15:0], read/write, k < NUM_ARGS
- R0 = 4+2·NUM_ARGS; R0+2j / R0+2j+1: resp[j] hi/lo, read-only
- Other indices read 0; writes to them are ignored

State machine:
- S_IDLE: on bus_request, go to S_WAIT and assert bus_ack next cycle; a write takes effect at that same edge.
- S_WAIT: always return to S_IDLE; bus_request is ignored here.

FIFO:
- A push stores the current arg registers as a snapshot; later arg writes do not alter queued entries.
- A pop occurs on cmd_valid & cmd_ready; it sets in_flight.
- rsp_valid with in_flight=1:
  - latches rsp_data and clears in_flight
  - sets error if rsp_error
  - sets irq_pending
- rsp_valid with in_flight=0 is ignored.
- Push when full with no pop that cycle: the entry is dropped and overflow is set (sticky).
- Push when full with a pop the same cycle: accepted.
- Push and pop on an empty FIFO: the push completes; the pop has no effect (cmd_valid was 0).
- Set and clear of the same flag in one cycle: set wins.
- Pointers wrap modulo CMD_DEPTH; an extra occupancy counter distinguishes full from empty.

## Timing
- Request at edge t: bus_ack=1 during cycle t+1, registers updated at t+1, next request accepted at t+2.
- bus_rdata is combinational from address and registers, gated by bus_ack.
- cmd_valid rises the cycle after the push edge (FIFO read is registered storage with fall-through, 1-cycle latency).
- Status reflects a pop or a response one cycle after its edge.
- Reset (reset=0 at an edge) clears:
  - state, FIFO, in_flight, all flags
  - args, responses, last command
  - bus_ack, bus_rdata, cmd_valid, cmd_id, cmd_args, irq = 0
- Reset mid-operation discards queued and in-flight commands; a later rsp_valid is ignored.

## Configuration
- N64_CFG_MBOX_IRQ_EN defined:
  - irq port exists and mirrors irq_pending
  - status bit 11 reports irq_pending
  - control bit2 clears it
- Not defined:
  - no irq port, no irq_pending register
  - status bit 11 reads 0; control bit2 is ignored

## Test plan
- Write arg0=0x1234_5678, write cmd 0x42 → cmd_valid after 1 cycle, cmd_id=0x42, cmd_args[31:0]=0x12345678; status busy=1, pending=1.
- Hold cmd_ready=0; push 5 commands with CMD_DEPTH=4 → pending=4, overflow=1, the 5th is lost; control write 0x0001 → overflow=0.
- Push cmd A, then rewrite arg0 before the pop → the popped cmd_args keep the old value.
- Pop, then rsp_valid with rsp_data=0xCAFEBABE, rsp_error=1 → resp halves read 0xCAFE/0xBABE, error=1, busy=0, irq=1 (with macro); control write 0x0006 clears both.
- Full FIFO, push and pop in the same cycle → pending stays 4, overflow=0.
- Reset asserted with 3 pending and one in flight → pending=0, busy=0, cmd_valid=0; a following rsp_valid leaves resp=0.
